// File: rtl/fpu_out_pkg.sv
// Shared definitions for the FPU result-port scheduler: pipe indices, result-ID
// field positions and the default per-core CPX queue depth.
package fpu_out_pkg;

  localparam int DIV       = 2;
  localparam int MUL       = 1;
  localparam int ADD       = 0;
  localparam int NUM_PIPES = 3;

  localparam int ID_W     = 10;
  localparam int CORE_MSB = 9;
  localparam int CORE_LSB = 2;
  localparam int THR_MSB  = 1;
  localparam int THR_LSB  = 0;

  localparam int DEFAULT_CREDITS = 2;

  function automatic logic [NUM_PIPES-1:0] pipe_onehot(input logic [1:0] idx);
    pipe_onehot = 3'b001 << idx;
  endfunction

endpackage

// File: rtl/fpu_out_credit.sv
// Credit counter for one destination core's CPX queue: issues consume an entry,
// grants return one, and a grant arriving at a full count is reported as overflow.
module fpu_out_credit
  import fpu_out_pkg::*;
#(
  parameter int CREDITS = DEFAULT_CREDITS
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic issue_i,
  input  logic grant_i,
  output logic avail_o,
  output logic ovf_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;

  // Issue and grant together cancel; the scheduler never issues at zero credit.
  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    if (grant_i && !issue_i) begin
      if (count_q == FULL) begin
        ovf_o = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (issue_i && !grant_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign avail_o = (count_q != '0);

endmodule

// File: rtl/fpu_out_sched.sv
// Round-robin, credit-gated arbiter sharing the FPU-to-CPX result port among the
// div, mul and add pipes; registers the pipe select, thread and CPX request.
module fpu_out_sched
  import fpu_out_pkg::*;
#(
  parameter int CREDITS  = DEFAULT_CREDITS,
  parameter int NUM_DEST = 8
) (
  input  logic                rclk,
  input  logic                arst_l,
  input  logic                d8stg_fdiv_in,
  input  logic                m6stg_fmul_in,
  input  logic                a6stg_fadd_in,
  input  logic [9:0]          div_id_out_in,
  input  logic [9:0]          m6stg_id_in,
  input  logic [9:0]          add_id_out_in,
  input  logic [NUM_DEST-1:0] cpx_fp_grant_cx,
  output logic [NUM_DEST-1:0] fp_cpx_req_cq,
  output logic [1:0]          req_thread,
  output logic [2:0]          dest_rdy,
  output logic                div_dest_rdy,
  output logic                mul_dest_rdy,
  output logic                add_dest_rdy,
  output logic                div_out_hold,
  output logic                mul_out_hold,
  output logic                add_out_hold,
  output logic [1:0]          sched_err
);

  logic [NUM_PIPES-1:0]                req;
  logic [NUM_PIPES-1:0][ID_W-1:0]      id;
  logic [NUM_PIPES-1:0][NUM_DEST-1:0]  core;
  logic [NUM_PIPES-1:0]                onehot;
  logic [NUM_PIPES-1:0]                illegal;
  logic [NUM_PIPES-1:0]                elig;

  logic [NUM_DEST-1:0] avail;
  logic [NUM_DEST-1:0] ovf;
  logic [NUM_DEST-1:0] issue;

  logic                 win_vld;
  logic [1:0]           win_idx;
  logic [1:0]           cand;
  logic [NUM_PIPES-1:0] win_oh;

  logic [NUM_PIPES-1:0] dest_rdy_q, dest_rdy_d;
  logic [NUM_DEST-1:0]  req_q, req_d;
  logic [1:0]           thr_q, thr_d;
  logic [1:0]           rr_last_q, rr_last_d;
  logic [1:0]           err_q, err_d;

  assign req = {d8stg_fdiv_in, m6stg_fmul_in, a6stg_fadd_in};
  assign id  = {div_id_out_in, m6stg_id_in, add_id_out_in};

  // A pipe is eligible only with a one-hot core field whose registered credit is non-zero.
  always_comb begin
    for (int p = 0; p < NUM_PIPES; p++) begin
      core[p]    = id[p][CORE_LSB +: NUM_DEST];
      onehot[p]  = (core[p] != '0) && ((core[p] & (core[p] - NUM_DEST'(1))) == '0);
      illegal[p] = req[p] && !onehot[p];
      elig[p]    = req[p] && onehot[p] && ((core[p] & avail) != '0);
    end
  end

  // Visiting order is div->mul->add (descending index) starting after rr_last;
  // lowest priority is scanned first so the highest-priority hit lands last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'(ADD);
    cand    = '0;
    for (int k = NUM_PIPES; k >= 1; k--) begin
      cand = 2'((int'(rr_last_q) + NUM_PIPES - k) % NUM_PIPES);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_oh     = '0;
    issue      = '0;
    dest_rdy_d = '0;
    req_d      = '0;
    thr_d      = '0;
    rr_last_d  = rr_last_q;
    if (win_vld) begin
      win_oh     = pipe_onehot(win_idx);
      issue      = core[win_idx];
      dest_rdy_d = win_oh;
      req_d      = core[win_idx];
      thr_d      = id[win_idx][THR_MSB:THR_LSB];
      rr_last_d  = win_idx;
    end
    err_d = err_q | {(|illegal), (|ovf)};
  end

  for (genvar d = 0; d < NUM_DEST; d++) begin : g_credit
    fpu_out_credit #(
      .CREDITS (CREDITS)
    ) u_credit (
      .clk_i   (rclk),
      .rst_n_i (arst_l),
      .issue_i (issue[d]),
      .grant_i (cpx_fp_grant_cx[d]),
      .avail_o (avail[d]),
      .ovf_o   (ovf[d])
    );
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      dest_rdy_q <= '0;
      req_q      <= '0;
      thr_q      <= '0;
      rr_last_q  <= 2'(ADD);
      err_q      <= '0;
    end else begin
      dest_rdy_q <= dest_rdy_d;
      req_q      <= req_d;
      thr_q      <= thr_d;
      rr_last_q  <= rr_last_d;
      err_q      <= err_d;
    end
  end

  // Holds are forced low during reset so every output reads zero while arst_l is asserted.
  assign {div_out_hold, mul_out_hold, add_out_hold} = req & ~win_oh & {NUM_PIPES{arst_l}};

  assign dest_rdy      = dest_rdy_q;
  assign div_dest_rdy  = dest_rdy_q[DIV];
  assign mul_dest_rdy  = dest_rdy_q[MUL];
  assign add_dest_rdy  = dest_rdy_q[ADD];
  assign fp_cpx_req_cq = req_q;
  assign req_thread    = thr_q;
  assign sched_err     = err_q;

endmodule

// File: tb/tb_fpu_out_sched.sv
// Scoreboard bench for fpu_out_sched: directed per-cycle vectors queue the expected
// registered output, and a negedge monitor compares whatever the DUT presents.
module tb_fpu_out_sched;

  logic       rclk;
  logic       arst_l;
  logic       d8stg_fdiv_in, m6stg_fmul_in, a6stg_fadd_in;
  logic [9:0] div_id_out_in, m6stg_id_in, add_id_out_in;
  logic [7:0] cpx_fp_grant_cx;
  logic [7:0] fp_cpx_req_cq;
  logic [1:0] req_thread;
  logic [2:0] dest_rdy;
  logic       div_dest_rdy, mul_dest_rdy, add_dest_rdy;
  logic       div_out_hold, mul_out_hold, add_out_hold;
  logic [1:0] sched_err;

  typedef struct {
    int         cyc;
    logic [2:0] dest;
    logic [7:0] req;
    logic [1:0] thr;
  } expT;

  expT expQ[$];
  int  cycleCnt   = 0;
  int  numVectors = 0;
  int  errCount   = 0;
  bit  monOn      = 0;

  fpu_out_sched #(.CREDITS(2), .NUM_DEST(8)) dut (
    .rclk            (rclk),
    .arst_l          (arst_l),
    .d8stg_fdiv_in   (d8stg_fdiv_in),
    .m6stg_fmul_in   (m6stg_fmul_in),
    .a6stg_fadd_in   (a6stg_fadd_in),
    .div_id_out_in   (div_id_out_in),
    .m6stg_id_in     (m6stg_id_in),
    .add_id_out_in   (add_id_out_in),
    .cpx_fp_grant_cx (cpx_fp_grant_cx),
    .fp_cpx_req_cq   (fp_cpx_req_cq),
    .req_thread      (req_thread),
    .dest_rdy        (dest_rdy),
    .div_dest_rdy    (div_dest_rdy),
    .mul_dest_rdy    (mul_dest_rdy),
    .add_dest_rdy    (add_dest_rdy),
    .div_out_hold    (div_out_hold),
    .mul_out_hold    (mul_out_hold),
    .add_out_hold    (add_out_hold),
    .sched_err       (sched_err)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  always @(posedge rclk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numVectors++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // vld = {div, mul, add}; expHold = {div, mul, add}
  task automatic applyStimulus(input logic [2:0] vld, input logic [9:0] dId, input logic [9:0] mId,
                               input logic [9:0] aId, input logic [7:0] grant, input logic [2:0] expHold,
                               input logic expOut, input logic [2:0] expDest, input logic [7:0] expReq,
                               input logic [1:0] expThr);
    @(posedge rclk);
    #1;
    d8stg_fdiv_in   = vld[2];
    m6stg_fmul_in   = vld[1];
    a6stg_fadd_in   = vld[0];
    div_id_out_in   = dId;
    m6stg_id_in     = mId;
    add_id_out_in   = aId;
    cpx_fp_grant_cx = grant;
    if (expOut) expQ.push_back('{cyc: cycleCnt + 1, dest: expDest, req: expReq, thr: expThr});
    #1;
    checkOutput("hold", 32'({div_out_hold, mul_out_hold, add_out_hold}), 32'(expHold));
  endtask

  task automatic clearInputs();
    d8stg_fdiv_in   = 1'b0;
    m6stg_fmul_in   = 1'b0;
    a6stg_fadd_in   = 1'b0;
    div_id_out_in   = '0;
    m6stg_id_in     = '0;
    add_id_out_in   = '0;
    cpx_fp_grant_cx = '0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_dest_rdy", 32'({dest_rdy, div_dest_rdy, mul_dest_rdy, add_dest_rdy}), 32'(0));
    checkOutput("rst_req", 32'(fp_cpx_req_cq), 32'(0));
    checkOutput("rst_thread", 32'(req_thread), 32'(0));
    checkOutput("rst_err", 32'(sched_err), 32'(0));
    checkOutput("rst_hold", 32'({div_out_hold, mul_out_hold, add_out_hold}), 32'(0));
  endtask

  // Scoreboard monitor: a due entry must match, otherwise the port must be idle.
  always @(negedge rclk) begin
    if (monOn && arst_l) begin
      while (expQ.size() > 0 && expQ[0].cyc < cycleCnt) begin
        expT stale;
        stale = expQ.pop_front();
        numVectors++;
        errCount++;
        $display("[TB] FAIL missed_output: got nothing at cycle %0d, expected dest 0x%0h req 0x%0h",
                 stale.cyc, stale.dest, stale.req);
      end
      if (expQ.size() > 0 && expQ[0].cyc == cycleCnt) begin
        expT e;
        e = expQ.pop_front();
        checkOutput("dest_rdy", 32'(dest_rdy), 32'(e.dest));
        checkOutput("dest_copies", 32'({div_dest_rdy, mul_dest_rdy, add_dest_rdy}), 32'(e.dest));
        checkOutput("cpx_req", 32'(fp_cpx_req_cq), 32'(e.req));
        checkOutput("req_thread", 32'(req_thread), 32'(e.thr));
      end else begin
        checkOutput("idle_out", 32'({dest_rdy, fp_cpx_req_cq, req_thread}), 32'(0));
      end
    end
  end

  initial begin
    arst_l = 1'b0;
    clearInputs();
    repeat (2) @(posedge rclk);
    #1;
    checkResetOutputs();
    @(negedge rclk);
    arst_l = 1'b1;
    monOn  = 1'b1;

    // Solo add result to core0 thread 2, then return its credit.
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h006, 8'h00, 3'b000, 1, 3'b001, 8'h01, 2'd2);
    applyStimulus(3'b000, 10'h000, 10'h000, 10'h000, 8'h01, 3'b000, 0, 3'b000, 8'h00, 2'd0);

    // Three-way contention on cores 1/2/3: div, mul, add in turn.
    applyStimulus(3'b111, 10'h009, 10'h012, 10'h023, 8'h00, 3'b011, 1, 3'b100, 8'h02, 2'd1);
    applyStimulus(3'b111, 10'h009, 10'h012, 10'h023, 8'h00, 3'b101, 1, 3'b010, 8'h04, 2'd2);
    applyStimulus(3'b111, 10'h009, 10'h012, 10'h023, 8'h00, 3'b110, 1, 3'b001, 8'h08, 2'd3);

    // Core3 at credit 1: issue with a same-cycle grant leaves exactly one credit.
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h020, 8'h08, 3'b000, 1, 3'b001, 8'h08, 2'd0);
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h021, 8'h00, 3'b000, 1, 3'b001, 8'h08, 2'd1);
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h022, 8'h00, 3'b001, 0, 3'b000, 8'h00, 2'd0);

    // Core5 exhaustion: two issue, third waits for a grant, issues the cycle after it.
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h080, 8'h00, 3'b000, 1, 3'b001, 8'h20, 2'd0);
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h081, 8'h00, 3'b000, 1, 3'b001, 8'h20, 2'd1);
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h082, 8'h00, 3'b001, 0, 3'b000, 8'h00, 2'd0);
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h082, 8'h20, 3'b001, 0, 3'b000, 8'h00, 2'd0);
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h082, 8'h00, 3'b000, 1, 3'b001, 8'h20, 2'd2);

    // Credit overflow on core0, then an illegal multi-hot mul ID.
    applyStimulus(3'b000, 10'h000, 10'h000, 10'h000, 8'h00, 3'b000, 0, 3'b000, 8'h00, 2'd0);
    checkOutput("err_clean", 32'(sched_err), 32'(0));
    applyStimulus(3'b000, 10'h000, 10'h000, 10'h000, 8'h01, 3'b000, 0, 3'b000, 8'h00, 2'd0);
    applyStimulus(3'b000, 10'h000, 10'h000, 10'h000, 8'h00, 3'b000, 0, 3'b000, 8'h00, 2'd0);
    checkOutput("err_overflow", 32'(sched_err), 32'(2'b01));
    applyStimulus(3'b010, 10'h000, 10'h00C, 10'h000, 8'h00, 3'b010, 0, 3'b000, 8'h00, 2'd0);
    applyStimulus(3'b010, 10'h000, 10'h00C, 10'h000, 8'h00, 3'b010, 0, 3'b000, 8'h00, 2'd0);
    applyStimulus(3'b110, 10'h004, 10'h00C, 10'h000, 8'h00, 3'b010, 1, 3'b100, 8'h01, 2'd0);
    checkOutput("err_illegal", 32'(sched_err), 32'(2'b11));

    // Contention burst interrupted by reset.
    applyStimulus(3'b111, 10'h005, 10'h011, 10'h040, 8'h00, 3'b101, 1, 3'b010, 8'h04, 2'd1);
    applyStimulus(3'b111, 10'h005, 10'h011, 10'h040, 8'h00, 3'b110, 1, 3'b001, 8'h10, 2'd0);
    @(negedge rclk);
    #1;
    arst_l = 1'b0;
    expQ.delete();
    #1;
    checkResetOutputs();
    clearInputs();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    arst_l = 1'b1;

    // After reset: cores 5 and 3 are full again and div wins first.
    applyStimulus(3'b111, 10'h080, 10'h021, 10'h082, 8'h00, 3'b011, 1, 3'b100, 8'h20, 2'd0);
    checkOutput("err_after_reset", 32'(sched_err), 32'(0));
    applyStimulus(3'b011, 10'h000, 10'h021, 10'h082, 8'h00, 3'b001, 1, 3'b010, 8'h08, 2'd1);
    applyStimulus(3'b001, 10'h000, 10'h000, 10'h082, 8'h00, 3'b000, 1, 3'b001, 8'h20, 2'd2);
    applyStimulus(3'b000, 10'h000, 10'h000, 10'h000, 8'h00, 3'b000, 0, 3'b000, 8'h00, 2'd0);
    @(negedge rclk);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, errCount);
    $finish;
  end

endmodule
